// File: rtl/branch_prediction_unit_r1.sv
// branch_prediction_unit_r1
// Direction predictor built from a table of saturating counters.
// MODE=0 indexes the table by address (bimodal); MODE=1 XORs the address
// with a global history register (gshare). The prediction is registered,
// then passes through DELAY extra stages. A retiring branch that writes the
// same entry a lookup reads in the same cycle is forwarded (write-first).

module branch_prediction_unit_r1 #(
    parameter int ADDR_WIDTH = 6,
    parameter int CTR_WIDTH  = 2,
    parameter int HIST_WIDTH = 4,
    parameter int MODE       = 0,
    parameter int DELAY      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  predictValid,
    input  logic [ADDR_WIDTH-1:0] predictAddr,
    input  logic                  update,
    input  logic [ADDR_WIDTH-1:0] updateAddr,
    input  logic                  branchTaken,
    output logic                  prediction,
    output logic                  predValid
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;
    // Weakly not-taken: just below the taken threshold (0 for 1-bit counters).
    localparam logic [CTR_WIDTH-1:0] WNT     = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [CTR_WIDTH-1:0] CTR_ONE = CTR_WIDTH'(1);

    logic [CTR_WIDTH-1:0]  ctr_tbl [ENTRIES];
    logic [ADDR_WIDTH-1:0] hist_ext;
    logic [ADDR_WIDTH-1:0] p_idx;
    logic [ADDR_WIDTH-1:0] u_idx;
    logic [CTR_WIDTH-1:0]  u_cur;
    logic [CTR_WIDTH-1:0]  u_next;
    logic                  raw_pred;
    logic [DELAY:0]        vld_pipe;
    logic [DELAY:0]        pred_pipe;

    // History source: a shift register in gshare mode, constant zero otherwise.
    generate
        if (MODE == 1) begin : g_gshare
            logic [HIST_WIDTH-1:0] ghr;
            logic [HIST_WIDTH-1:0] ghr_next;

            if (HIST_WIDTH == 1) begin : g_h1
                assign ghr_next = branchTaken;
            end else begin : g_hn
                assign ghr_next = {ghr[HIST_WIDTH-2:0], branchTaken};
            end

            // Shift the resolved direction in on each retiring branch.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ghr <= '0;
                end else if (update) begin
                    ghr <= ghr_next;
                end
            end

            // Zero-extend the history to index width.
            assign hist_ext = ADDR_WIDTH'(ghr);
        end else begin : g_bimodal
            assign hist_ext = '0;
        end
    endgenerate

    // Both paths use the history held at the start of the cycle.
    assign p_idx = predictAddr ^ hist_ext;
    assign u_idx = updateAddr ^ hist_ext;
    assign u_cur = ctr_tbl[u_idx];

    // Saturating step of the counter being retired; never wraps.
    always_comb begin
        u_next = u_cur;
        if (branchTaken) begin
            if (u_cur != CTR_MAX) u_next = u_cur + CTR_ONE;
        end else begin
            if (u_cur != '0) u_next = u_cur - CTR_ONE;
        end
    end

    // Raw direction: forward the post-update value on an index collision.
    always_comb begin
        raw_pred = ctr_tbl[p_idx][CTR_WIDTH-1];
        if (update && (p_idx == u_idx)) raw_pred = u_next[CTR_WIDTH-1];
    end

    // Counter table: flops, reset to weakly not-taken, one write per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr_tbl[i] <= WNT;
        end else if (update) begin
            ctr_tbl[u_idx] <= u_next;
        end
    end

    // Base output register followed by DELAY shift stages; reset flushes all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            pred_pipe <= '0;
        end else begin
            vld_pipe[0]  <= predictValid;
            pred_pipe[0] <= raw_pred;
            for (int s = 1; s <= DELAY; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                pred_pipe[s] <= pred_pipe[s-1];
            end
        end
    end

    assign prediction = pred_pipe[DELAY];
    assign predValid  = vld_pipe[DELAY];

endmodule

// File: tb/tb_branch_prediction_unit_r1.sv
// Directed bench for branch_prediction_unit_r1. Four instances cover
// bimodal/2-bit, gshare/4-bit history, DELAY=2 and 3-bit counters; each has
// its own stimulus lanes, and all share clock and reset.

module tb_branch_prediction_unit_r1;

    logic       clk;
    logic       rst;
    logic       pv [4];
    logic [5:0] pa [4];
    logic       up [4];
    logic [5:0] ua [4];
    logic       bt [4];
    logic       pr [4];
    logic       vo [4];

    int n_cmp;
    int n_err;

    // d0: bimodal, 2-bit counters, no extra delay
    branch_prediction_unit_r1 #(.ADDR_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(4), .MODE(0), .DELAY(0)) d0 (
        .clk(clk), .rst(rst), .predictValid(pv[0]), .predictAddr(pa[0]), .update(up[0]),
        .updateAddr(ua[0]), .branchTaken(bt[0]), .prediction(pr[0]), .predValid(vo[0]));
    // d1: gshare, 4-bit history
    branch_prediction_unit_r1 #(.ADDR_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(4), .MODE(1), .DELAY(0)) d1 (
        .clk(clk), .rst(rst), .predictValid(pv[1]), .predictAddr(pa[1]), .update(up[1]),
        .updateAddr(ua[1]), .branchTaken(bt[1]), .prediction(pr[1]), .predValid(vo[1]));
    // d2: bimodal, two extra output stages
    branch_prediction_unit_r1 #(.ADDR_WIDTH(6), .CTR_WIDTH(2), .HIST_WIDTH(4), .MODE(0), .DELAY(2)) d2 (
        .clk(clk), .rst(rst), .predictValid(pv[2]), .predictAddr(pa[2]), .update(up[2]),
        .updateAddr(ua[2]), .branchTaken(bt[2]), .prediction(pr[2]), .predValid(vo[2]));
    // d3: bimodal, 3-bit counters
    branch_prediction_unit_r1 #(.ADDR_WIDTH(6), .CTR_WIDTH(3), .HIST_WIDTH(4), .MODE(0), .DELAY(0)) d3 (
        .clk(clk), .rst(rst), .predictValid(pv[3]), .predictAddr(pa[3]), .update(up[3]),
        .updateAddr(ua[3]), .branchTaken(bt[3]), .prediction(pr[3]), .predValid(vo[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus on lane k, then lane returns idle.
    task automatic cyc(input int k, input logic p, input logic [5:0] a,
                       input logic u, input logic [5:0] b, input logic t);
        pv[k] = p; pa[k] = a; up[k] = u; ua[k] = b; bt[k] = t;
        tick();
        pv[k] = 1'b0; up[k] = 1'b0;
    endtask

    task automatic upd(input int k, input logic [5:0] b, input logic t);
        cyc(k, 1'b0, 6'd0, 1'b1, b, t);
    endtask

    task automatic prd(input int k, input logic [5:0] a);
        cyc(k, 1'b1, a, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int k = 0; k < 4; k++) begin
            pv[k] = 1'b0; pa[k] = '0; up[k] = 1'b0; ua[k] = '0; bt[k] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        chk("reset_vld", vo[0], 1'b0);
        chk("reset_pred", pr[0], 1'b0);
        rst = 1'b0;

        // ---- d0: first lookup after reset, weakly not-taken
        prd(0, 6'd5);
        chk("first_vld", vo[0], 1'b1);
        chk("first_pred", pr[0], 1'b0);
        tick();
        chk("idle_vld", vo[0], 1'b0);

        // ---- d0: saturation at addr 3 (1->2->3->3)
        upd(0, 6'd3, 1'b1);
        upd(0, 6'd3, 1'b1);
        upd(0, 6'd3, 1'b1);
        prd(0, 6'd3);
        chk("sat_hi_pred", pr[0], 1'b1);
        upd(0, 6'd3, 1'b0);            // 3 -> 2
        prd(0, 6'd3);
        chk("sat_ctr2_pred", pr[0], 1'b1);
        upd(0, 6'd3, 1'b0);            // 2 -> 1
        upd(0, 6'd3, 1'b0);            // 1 -> 0
        prd(0, 6'd3);
        chk("sat_ctr0_pred", pr[0], 1'b0);
        upd(0, 6'd3, 1'b0);            // stays 0, must not wrap to 3
        prd(0, 6'd3);
        chk("no_wrap_pred", pr[0], 1'b0);
        upd(0, 6'd3, 1'b1);            // 0 -> 1
        prd(0, 6'd3);
        chk("floor_ctr1_pred", pr[0], 1'b0);
        upd(0, 6'd3, 1'b1);            // 1 -> 2
        prd(0, 6'd3);
        chk("floor_ctr2_pred", pr[0], 1'b1);

        // ---- d0: same-cycle bypass at addr 7 (counter 1 -> 2)
        cyc(0, 1'b1, 6'd7, 1'b1, 6'd7, 1'b1);
        chk("bypass_vld", vo[0], 1'b1);
        chk("bypass_pred", pr[0], 1'b1);
        cyc(0, 1'b1, 6'd8, 1'b1, 6'd7, 1'b1);   // addr 7 -> 3, addr 8 untouched
        chk("nobypass_pred", pr[0], 1'b0);

        // ---- d1: gshare, build GHR = 4'b1011
        upd(1, 6'h00, 1'b1);           // idx 00 -> 2, ghr 0001
        upd(1, 6'h00, 1'b0);           // idx 01 -> 0, ghr 0010
        upd(1, 6'h00, 1'b1);           // idx 02 -> 2, ghr 0101
        upd(1, 6'h00, 1'b1);           // idx 05 -> 2, ghr 1011
        prd(1, 6'h10);                 // reads 0x1B, counter 1
        chk("gs_untrained_pred", pr[1], 1'b0);
        // Train entry 0x1B twice while returning the history to 1011.
        upd(1, 6'h20, 1'b1);           // idx 2B, ghr 0111
        upd(1, 6'h20, 1'b0);           // idx 27, ghr 1110
        upd(1, 6'h15, 1'b1);           // idx 1B -> 2, ghr 1101
        upd(1, 6'h16, 1'b1);           // idx 1B -> 3, ghr 1011
        prd(1, 6'h10);
        chk("gs_trained_pred", pr[1], 1'b1);
        prd(1, 6'h1B);                 // reads 0x10, counter 1
        chk("gs_other_pred", pr[1], 1'b0);
        // Same-cycle update/predict, both indexed with the pre-update GHR 1011.
        cyc(1, 1'b1, 6'h10, 1'b1, 6'h10, 1'b0);  // idx 1B: 3 -> 2, ghr 0110
        chk("gs_bypass_pred", pr[1], 1'b1);
        prd(1, 6'h10);                 // now reads 0x16, counter 1
        chk("gs_shifted_pred", pr[1], 1'b0);

        // ---- d2: DELAY=2 latency; addr 4 trained taken, addr 5 not
        upd(2, 6'd4, 1'b1);
        upd(2, 6'd4, 1'b1);
        prd(2, 6'd4);                  // edge N
        chk("lat_n1_vld", vo[2], 1'b0);
        tick();
        chk("lat_n2_vld", vo[2], 1'b0);
        tick();
        chk("lat_n3_vld", vo[2], 1'b1);
        chk("lat_n3_pred", pr[2], 1'b1);
        tick();
        chk("lat_n4_vld", vo[2], 1'b0);
        prd(2, 6'd4);                  // back-to-back N, N+1
        prd(2, 6'd5);
        chk("b2b_n2_vld", vo[2], 1'b0);
        tick();
        chk("b2b_first_vld", vo[2], 1'b1);
        chk("b2b_first_pred", pr[2], 1'b1);
        tick();
        chk("b2b_second_vld", vo[2], 1'b1);
        chk("b2b_second_pred", pr[2], 1'b0);
        tick();
        chk("b2b_done_vld", vo[2], 1'b0);

        // ---- d3: 3-bit counters, WNT = 3
        prd(3, 6'd2);
        chk("c3_wnt_pred", pr[3], 1'b0);
        upd(3, 6'd2, 1'b1);            // 3 -> 4
        prd(3, 6'd2);
        chk("c3_one_taken_pred", pr[3], 1'b1);
        for (int i = 0; i < 6; i++) upd(3, 6'd2, 1'b1);   // saturates at 7
        for (int i = 0; i < 3; i++) upd(3, 6'd2, 1'b0);   // 7 -> 4
        prd(3, 6'd2);
        chk("c3_sat_pred", pr[3], 1'b1);
        upd(3, 6'd2, 1'b0);            // 4 -> 3
        prd(3, 6'd2);
        chk("c3_below_pred", pr[3], 1'b0);

        // ---- d0: asynchronous reset mid-stream (addr 3 counter is 2)
        pv[0] = 1'b1; pa[0] = 6'd3;
        tick();
        chk("pre_rst_vld", vo[0], 1'b1);
        chk("pre_rst_pred", pr[0], 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_vld", vo[0], 1'b0);
        chk("async_rst_pred", pr[0], 1'b0);
        tick();
        rst = 1'b0;
        tick();                        // lookup addr 3 still requested
        chk("post_rst_vld", vo[0], 1'b1);
        chk("post_rst_pred", pr[0], 1'b0);
        pv[0] = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
